// File: rtl/wb_pkg.sv
// wb_pkg: cause encodings, exception table, TLB op codes, FSM states and fill-LFSR constants
package wb_pkg;
  localparam int EXC_N = 15;
  localparam int C_INT = 0, C_ADEF = 1, C_TLBR_F = 2, C_PIF = 3, C_PPI_F = 4;
  localparam int C_INE = 5, C_SYS = 6, C_BRK = 7, C_INVTLBOP = 8, C_ALE = 9;
  localparam int C_TLBR_M = 10, C_PIL = 11, C_PIS = 12, C_PME = 13, C_PPI_M = 14;
  localparam logic [2:0] TLB_NONE = 3'd0, TLB_RD = 3'd1, TLB_WR = 3'd2, TLB_FILL = 3'd3, TLB_INV = 3'd4;
  localparam logic [1:0] ST_RUN = 2'd0, ST_TLBWAIT = 2'd1, ST_FLUSH = 2'd2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1, LFSR_TAPS = 16'h002D;
  typedef struct packed {
    logic [5:0] ecode;
    logic [8:0] esubcode;
    logic       mem;
  } exc_info_t;
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      result;
    logic [31:0]      badv;
    logic             gr_we;
    logic [4:0]       dest;
    logic [EXC_N-1:0] exc;
    logic             ertn;
    logic             rdcntid;
    logic [2:0]       tlbop;
    logic             csr_we;
    logic [13:0]      csr_num;
    logic [31:0]      csr_wdata;
    logic [31:0]      csr_wmask;
  } stage_t;
  // Causes from ALE upward carry a data address, so badv comes from MEM rather than the PC
  function automatic exc_info_t exc_info(input logic [3:0] i);
    logic [5:0] e;
    case (i)
      4'd0:    e = 6'h00;
      4'd1:    e = 6'h08;
      4'd2:    e = 6'h3F;
      4'd3:    e = 6'h03;
      4'd4:    e = 6'h07;
      4'd5:    e = 6'h0D;
      4'd6:    e = 6'h0B;
      4'd7:    e = 6'h0C;
      4'd8:    e = 6'h0D;
      4'd9:    e = 6'h09;
      4'd10:   e = 6'h3F;
      4'd11:   e = 6'h01;
      4'd12:   e = 6'h02;
      4'd13:   e = 6'h04;
      default: e = 6'h07;
    endcase
    return '{ecode: e, esubcode: 9'd0, mem: 32'(i) >= C_ALE};
  endfunction
endpackage

// File: rtl/wb_fill_idx.sv
// wb_fill_idx: free-running TLBFILL index source, counter or 16-bit LFSR
module wb_fill_idx
  import wb_pkg::*;
#(
  parameter int IW = 4,
  parameter int FILL_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] idx
);
  if (FILL_MODE == 1) begin : g_lfsr
    logic [15:0] lfsr;
    always_ff @(posedge clk) lfsr <= reset ? LFSR_SEED : {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    assign idx = lfsr[IW-1:0];
  end else begin : g_cnt
    logic [IW-1:0] cnt;
    always_ff @(posedge clk) cnt <= reset ? '0 : cnt + IW'(1);
    assign idx = cnt;
  end
endmodule

// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage retiring GPR/CSR writes, precise exceptions and TLB op sequencing
module wb_commit
  import wb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int FILL_MODE = 0,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_valid,
  output logic             ms_ready,
  input  logic [31:0]      ms_pc,
  input  logic [31:0]      ms_result,
  input  logic [31:0]      ms_badv,
  input  logic             ms_gr_we,
  input  logic [4:0]       ms_dest,
  input  logic [EXC_N-1:0] ms_exc,
  input  logic             ms_ertn,
  input  logic             ms_rdcntid,
  input  logic [2:0]       ms_tlbop,
  input  logic             ms_csr_we,
  input  logic [13:0]      ms_csr_num,
  input  logic [31:0]      ms_csr_wdata,
  input  logic [31:0]      ms_csr_wmask,
  input  logic [31:0]      csr_tid,
  input  logic [31:0]      csr_tlbidx,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [31:0]      csr_wdata,
  output logic [31:0]      csr_wmask,
  output logic             ex_valid,
  output logic [5:0]       ex_ecode,
  output logic [8:0]       ex_esubcode,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_badv,
  output logic             ertn_flush,
  output logic             flush,
  output logic [31:0]      refetch_pc,
  output logic             tlb_we,
  output logic [IW-1:0]    tlb_windex,
  output logic             tlb_rd,
  output logic [IW-1:0]    tlb_rindex,
  output logic             tlb_inv,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);
  logic          ws_valid, live, exc_any, hold, tlb_go, retire, unused_tlbidx;
  logic [1:0]    state;
  logic [3:0]    sel;
  logic [IW-1:0] fill_idx;
  stage_t        ws;
  exc_info_t     info;
  wb_fill_idx #(.IW(IW), .FILL_MODE(FILL_MODE)) u_fill (.clk(clk), .reset(reset), .idx(fill_idx));
  assign unused_tlbidx = ^csr_tlbidx[31:IW];
  assign live     = ws_valid & (state == ST_RUN);
  assign exc_any  = |ws.exc;
  assign hold     = exc_any | ws.ertn | (ws.tlbop != TLB_NONE);
  assign ms_ready = !ws_valid | ((state == ST_RUN) & !hold);
  assign retire   = live & !exc_any;
  assign tlb_go   = retire & (ws.tlbop != TLB_NONE);
  always_comb begin
    sel = '0;
    for (int i = EXC_N - 1; i >= 0; i--) if (ws.exc[i]) sel = 4'(i);
  end
  assign info        = exc_info(sel);
  assign ex_valid    = live & exc_any;
  assign ex_ecode    = ex_valid ? info.ecode : '0;
  assign ex_esubcode = ex_valid ? info.esubcode : '0;
  assign ex_pc       = ex_valid ? ws.pc : '0;
  assign ex_badv     = ex_valid ? (info.mem ? ws.badv : ws.pc) : '0;
  assign ertn_flush  = retire & ws.ertn;
  assign flush       = ex_valid | ertn_flush | (state == ST_FLUSH);
  assign refetch_pc  = (state == ST_FLUSH) ? ws.pc + 32'd4 : '0;
  assign rf_we       = retire & ws.gr_we;
  assign rf_waddr    = rf_we ? ws.dest : '0;
  assign rf_wdata    = rf_we ? (ws.rdcntid ? csr_tid : ws.result) : '0;
  assign csr_we      = retire & ws.csr_we;
  assign csr_num     = csr_we ? ws.csr_num : '0;
  assign csr_wdata   = csr_we ? ws.csr_wdata : '0;
  assign csr_wmask   = csr_we ? ws.csr_wmask : '0;
  assign tlb_we      = tlb_go & ((ws.tlbop == TLB_WR) | (ws.tlbop == TLB_FILL));
  assign tlb_windex  = tlb_we ? ((ws.tlbop == TLB_FILL) ? fill_idx : csr_tlbidx[IW-1:0]) : '0;
  assign tlb_rd      = tlb_go & (ws.tlbop == TLB_RD);
  assign tlb_rindex  = tlb_rd ? csr_tlbidx[IW-1:0] : '0;
  assign tlb_inv     = tlb_go & (ws.tlbop == TLB_INV);
  assign debug_wb_pc       = live ? ws.pc : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  // The TLB instruction stays in the stage through TLBWAIT/FLUSH so its PC feeds the refetch target
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      state    <= ST_RUN;
    end else if (state == ST_FLUSH) begin
      ws_valid <= 1'b0;
      state    <= ST_RUN;
    end else if (state == ST_TLBWAIT) state <= ST_FLUSH;
    else if (tlb_go) state <= ST_TLBWAIT;
    else if (ex_valid | ertn_flush) ws_valid <= 1'b0;
    else if (ms_ready) ws_valid <= ms_valid;
  end
  always_ff @(posedge clk)
    if (ms_valid & ms_ready)
      ws <= '{pc: ms_pc, result: ms_result, badv: ms_badv, gr_we: ms_gr_we, dest: ms_dest,
              exc: ms_exc, ertn: ms_ertn, rdcntid: ms_rdcntid, tlbop: ms_tlbop, csr_we: ms_csr_we,
              csr_num: ms_csr_num, csr_wdata: ms_csr_wdata, csr_wmask: ms_csr_wmask};
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed and randomized checks of wb_commit against a behavioural model
module tb_wb_commit;
  localparam int TLBNUM = 16;
  typedef struct packed {
    logic [31:0] pc, result, badv;
    logic        gr_we;
    logic [4:0]  dest;
    logic [14:0] exc;
    logic        ertn, rdcntid;
    logic [2:0]  tlbop;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata, csr_wmask, tid, tlbidx;
  } ins_t;
  logic clk = 0, reset = 1;
  logic ms_valid = 0, ms_ready;
  logic [31:0] ms_pc = 0, ms_result = 0, ms_badv = 0;
  logic ms_gr_we = 0, ms_ertn = 0, ms_rdcntid = 0, ms_csr_we = 0;
  logic [4:0] ms_dest = 0;
  logic [14:0] ms_exc = 0;
  logic [2:0] ms_tlbop = 0;
  logic [13:0] ms_csr_num = 0;
  logic [31:0] ms_csr_wdata = 0, ms_csr_wmask = 0, csr_tid = 0, csr_tlbidx = 0;
  logic rf_we, csr_we, ex_valid, ertn_flush, flush, tlb_we, tlb_rd, tlb_inv;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_wdata, csr_wmask, ex_pc, ex_badv, refetch_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0] ex_ecode;
  logic [8:0] ex_esubcode;
  logic [3:0] tlb_windex, tlb_rindex, debug_wb_rf_wen;
  int checks = 0, errors = 0, cyc = 0;
  logic [5:0] ecode_tab [15] = '{6'h00, 6'h08, 6'h3F, 6'h03, 6'h07, 6'h0D, 6'h0B, 6'h0C,
                                 6'h0D, 6'h09, 6'h3F, 6'h01, 6'h02, 6'h04, 6'h07};
  wb_commit #(.TLBNUM(TLBNUM), .FILL_MODE(0)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_pc(ms_pc),
    .ms_result(ms_result), .ms_badv(ms_badv), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_exc(ms_exc), .ms_ertn(ms_ertn), .ms_rdcntid(ms_rdcntid), .ms_tlbop(ms_tlbop),
    .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wdata(ms_csr_wdata),
    .ms_csr_wmask(ms_csr_wmask), .csr_tid(csr_tid), .csr_tlbidx(csr_tlbidx), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .ex_valid(ex_valid), .ex_ecode(ex_ecode),
    .ex_esubcode(ex_esubcode), .ex_pc(ex_pc), .ex_badv(ex_badv), .ertn_flush(ertn_flush),
    .flush(flush), .refetch_pc(refetch_pc), .tlb_we(tlb_we), .tlb_windex(tlb_windex),
    .tlb_rd(tlb_rd), .tlb_rindex(tlb_rindex), .tlb_inv(tlb_inv), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  always #5 clk = ~clk;
  // Cycles elapsed since reset was last sampled; the counter fill policy should track this
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input ins_t x);
    ms_valid = 1; ms_pc = x.pc; ms_result = x.result; ms_badv = x.badv; ms_gr_we = x.gr_we;
    ms_dest = x.dest; ms_exc = x.exc; ms_ertn = x.ertn; ms_rdcntid = x.rdcntid;
    ms_tlbop = x.tlbop; ms_csr_we = x.csr_we; ms_csr_num = x.csr_num;
    ms_csr_wdata = x.csr_wdata; ms_csr_wmask = x.csr_wmask; csr_tid = x.tid; csr_tlbidx = x.tlbidx;
  endtask
  task automatic do_reset();
    reset = 1; ms_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  function automatic ins_t rnd_ins();
    ins_t x;
    x = ins_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    x.pc = {x.pc[31:2], 2'b00};
    x.exc = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'd0;
    x.ertn = $urandom_range(0, 7) == 0;
    x.tlbop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
    return x;
  endfunction
  // Issue one instruction into an empty stage and check every cycle until the stage is empty again
  task automatic run_ins(input ins_t x);
    logic ex, er, tl, wr;
    logic [14:0] lsb;
    int k;
    ex = |x.exc;
    er = x.ertn & !ex;
    tl = !ex & (x.tlbop != 0);
    wr = !ex & x.gr_we;
    lsb = x.exc & (~x.exc + 15'd1);
    k = $clog2(lsb);
    chk("ready_before", ms_ready, 1);
    drive(x);
    @(negedge clk);
    ms_valid = 0;
    chk("rf_we", rf_we, wr);
    chk("rf_waddr", rf_waddr, wr ? x.dest : 5'd0);
    chk("rf_wdata", rf_wdata, wr ? (x.rdcntid ? x.tid : x.result) : 0);
    chk("dbg_wen", debug_wb_rf_wen, {4{wr}});
    chk("dbg_wdata", debug_wb_rf_wdata, wr ? (x.rdcntid ? x.tid : x.result) : 0);
    chk("csr_we", csr_we, !ex & x.csr_we);
    chk("csr_num", csr_num, (!ex & x.csr_we) ? x.csr_num : 14'd0);
    chk("csr_wdata", csr_wdata, (!ex & x.csr_we) ? x.csr_wdata : 0);
    chk("csr_wmask", csr_wmask, (!ex & x.csr_we) ? x.csr_wmask : 0);
    chk("ex_valid", ex_valid, ex);
    chk("ex_ecode", ex_ecode, ex ? ecode_tab[k] : 6'd0);
    chk("ex_esubcode", ex_esubcode, 0);
    chk("ex_pc", ex_pc, ex ? x.pc : 0);
    chk("ex_badv", ex_badv, ex ? (k >= 9 ? x.badv : x.pc) : 0);
    chk("ertn_flush", ertn_flush, er);
    chk("flush_t1", flush, ex | er);
    chk("tlb_we", tlb_we, tl & (x.tlbop == 2 || x.tlbop == 3));
    chk("tlb_windex", tlb_windex, !(tl & (x.tlbop == 2 || x.tlbop == 3)) ? 0 :
        (x.tlbop == 3 ? 32'(cyc % TLBNUM) : 32'(x.tlbidx[3:0])));
    chk("tlb_rd", tlb_rd, tl & (x.tlbop == 1));
    chk("tlb_rindex", tlb_rindex, (tl & (x.tlbop == 1)) ? x.tlbidx[3:0] : 4'd0);
    chk("tlb_inv", tlb_inv, tl & (x.tlbop == 4));
    chk("ready_t1", ms_ready, !(ex | x.ertn | (x.tlbop != 0)));
    if (tl) begin
      @(negedge clk);
      chk("wait_strobe", {tlb_we, tlb_rd, tlb_inv}, 0);
      chk("wait_flush", flush, 0);
      chk("wait_ready", ms_ready, 0);
      @(negedge clk);
      chk("fsm_flush", flush, 1);
      chk("refetch_pc", refetch_pc, x.pc + 32'd4);
      chk("flush_ready", ms_ready, 0);
      chk("flush_rf_we", rf_we, 0);
    end
    @(negedge clk);
    chk("empty_ready", ms_ready, 1);
    chk("empty_flush", flush, 0);
    chk("empty_ex", ex_valid, 0);
    chk("empty_rf_we", rf_we, 0);
    chk("empty_refetch", refetch_pc, 0);
  endtask
  initial begin
    ins_t a, b;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ms_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_ex", ex_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_tlb", {tlb_we, tlb_rd, tlb_inv, tlb_windex, tlb_rindex}, 0);
    chk("rst_dbg", debug_wb_rf_wen, 0);
    reset = 0;
    a = '0; a.pc = 32'h1C00_0000; a.gr_we = 1; a.dest = 5; a.result = 32'h1234;
    run_ins(a);
    a = '0; a.pc = 32'h1C00_0010; a.badv = 32'hDEAD_BEE1; a.gr_we = 1; a.dest = 3;
    a.exc = 15'((1 << 9) | (1 << 11));
    run_ins(a);
    a = '0; a.pc = 32'h1C00_0020; a.badv = 32'h55; a.exc = 15'((1 << 0) | (1 << 6)); a.csr_we = 1;
    run_ins(a);
    a = '0; a.pc = 32'hFFFF_FFFC; a.tlbop = 3'd2; a.tlbidx = 32'h7;
    run_ins(a);
    a = '0; a.pc = 32'h1C00_0030; a.ertn = 1;
    run_ins(a);
    do_reset();
    repeat (9) @(negedge clk);
    a = '0; a.pc = 32'h1C00_0040; a.tlbop = 3'd3;
    drive(a);
    @(negedge clk);
    ms_valid = 0;
    chk("fill_we", tlb_we, 1);
    chk("fill_at_10", tlb_windex, 10);
    repeat (3) @(negedge clk);
    a = '0; a.pc = 32'h1C00_0050; a.tlbop = 3'd2; a.tlbidx = 32'h3;
    drive(a);
    @(negedge clk);
    chk("rst_fsm_strobe", tlb_we, 1);
    ms_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_fsm_flush", flush, 0);
    chk("rst_fsm_we", tlb_we, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_fsm_ready", ms_ready, 1);
    chk("rst_fsm_flush2", flush, 0);
    a = '0; a.pc = 32'h1C00_0060; a.tlbop = 3'd4;
    b = '0; b.pc = 32'h1C00_0064; b.gr_we = 1; b.dest = 9; b.result = 32'hCAFE_0001;
    drive(a);
    @(negedge clk);
    chk("inv_strobe", tlb_inv, 1);
    drive(b);
    @(negedge clk);
    chk("blk_wait_ready", ms_ready, 0);
    @(negedge clk);
    chk("blk_flush", flush, 1);
    chk("blk_flush_ready", ms_ready, 0);
    chk("blk_refetch", refetch_pc, 32'h1C00_0064);
    @(negedge clk);
    chk("blk_ready_after", ms_ready, 1);
    chk("blk_no_rf", rf_we, 0);
    @(negedge clk);
    ms_valid = 0;
    chk("blk_retire", rf_we, 1);
    chk("blk_wdata", rf_wdata, 32'hCAFE_0001);
    chk("blk_no_strobe", tlb_inv, 0);
    @(negedge clk);
    a = '0; a.gr_we = 1; a.dest = 1; a.result = 32'hA;
    b = '0; b.gr_we = 1; b.dest = 2; b.result = 32'hB;
    drive(a);
    @(negedge clk);
    chk("b2b_a", rf_wdata, 32'hA);
    chk("b2b_ready", ms_ready, 1);
    drive(b);
    @(negedge clk);
    ms_valid = 0;
    chk("b2b_b", rf_wdata, 32'hB);
    chk("b2b_baddr", rf_waddr, 2);
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      run_ins(rnd_ins());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
